// File: rtl/lector_teclado.sv
// 4x4 matrix keypad scanner with debounce that builds two 3-digit BCD operands.
// Optional macro LECTOR_DESPLAZA_EN: 4th and later digits shift in, dropping the hundreds digit.
module lector_teclado #(
  parameter int SCAN_DIV = 27000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [3:0] dig1_1,
  output logic [3:0] dig1_2,
  output logic [3:0] dig1_3,
  output logic [3:0] dig2_1,
  output logic [3:0] dig2_2,
  output logic [3:0] dig2_3,
  output logic       operandos_listos,
  output logic [1:0] estado,
  output logic [3:0] tecla,
  output logic       tecla_valida
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_N = DW'(DEBOUNCE);
`ifdef LECTOR_DESPLAZA_EN
  localparam bit SHIFT_PAST_3 = 1'b1;
`else
  localparam bit SHIFT_PAST_3 = 1'b0;
`endif

  typedef enum logic [1:0] {ST_OP1 = 2'b00, ST_OP2 = 2'b01, ST_DONE = 2'b10} estado_t;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;   4'h1: code = 4'd2;  4'h2: code = 4'd3;   4'h3: code = 4'd10;
      4'h4: code = 4'd4;   4'h5: code = 4'd5;  4'h6: code = 4'd6;   4'h7: code = 4'd11;
      4'h8: code = 4'd7;   4'h9: code = 4'd8;  4'hA: code = 4'd9;   4'hB: code = 4'd12;
      4'hC: code = 4'd14;  4'hD: code = 4'd0;  4'hE: code = 4'd15;  default: code = 4'd13;
    endcase
    return code;
  endfunction

  logic [CW-1:0] dwell_reg;
  logic [1:0]    row_reg;
  logic [3:0]    sync1_reg, sync2_reg;
  logic          frame_hit_reg;
  logic [3:0]    frame_key_reg;
  logic          released_reg;
  logic [3:0]    cand_key_reg;
  logic [DW-1:0] cand_cnt_reg, none_cnt_reg;
  logic [3:0]    op1_reg [3];
  logic [3:0]    op2_reg [3];
  logic [1:0]    cnt1_reg, cnt2_reg;
  logic [3:0]    tecla_reg;
  logic          tecla_valida_reg;
  estado_t       state_reg, state_next;

  logic          sample, first_row, frame_done, row_hit;
  logic [3:0]    col_low, frame_key_now;
  logic [1:0]    row_col;
  logic          frame_hit_now, accept, is_digit, clear_all, load1, load2;
  logic [DW-1:0] cand_cnt_inc, none_cnt_inc;

  assign sample     = (dwell_reg == DWELL_LAST);
  assign first_row  = (row_reg == 2'd0);
  assign frame_done = sample && (row_reg == 2'd3);
  assign col_low    = ~sync2_reg;
  assign row_hit    = |col_low;

  always_comb begin
    row_col = 2'd3;
    if (col_low[0])      row_col = 2'd0;
    else if (col_low[1]) row_col = 2'd1;
    else if (col_low[2]) row_col = 2'd2;
  end

  // The first hit of a frame wins; later rows cannot override it.
  assign frame_hit_now = row_hit | (frame_hit_reg & ~first_row);
  assign frame_key_now = (frame_hit_reg && !first_row) ? frame_key_reg : key_code(row_reg, row_col);

  assign cand_cnt_inc = (cand_cnt_reg != '0 && cand_key_reg == frame_key_now) ? cand_cnt_reg + DW'(1) : DW'(1);
  assign none_cnt_inc = none_cnt_reg + DW'(1);
  assign accept       = frame_done && released_reg && frame_hit_now && (cand_cnt_inc == DEB_N);

  assign is_digit  = (frame_key_now <= 4'd9);
  assign clear_all = accept && (frame_key_now == 4'd12);
  assign load1     = accept && is_digit && state_reg == ST_OP1 && (cnt1_reg != 2'd3 || SHIFT_PAST_3);
  assign load2     = accept && is_digit && state_reg == ST_OP2 && (cnt2_reg != 2'd3 || SHIFT_PAST_3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_reg     <= '0;
      row_reg       <= 2'd0;
      sync1_reg     <= 4'hF;
      sync2_reg     <= 4'hF;
      frame_hit_reg <= 1'b0;
      frame_key_reg <= 4'd0;
    end else begin
      sync1_reg <= columnas;
      sync2_reg <= sync1_reg;
      if (sample) begin
        dwell_reg     <= '0;
        row_reg       <= row_reg + 2'd1;
        frame_hit_reg <= frame_hit_now;
        frame_key_reg <= frame_key_now;
      end else begin
        dwell_reg <= dwell_reg + CW'(1);
      end
    end
  end

  // Armed: look for DEBOUNCE equal key frames. Disarmed: wait for DEBOUNCE empty frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      released_reg <= 1'b0;
      cand_key_reg <= 4'd0;
      cand_cnt_reg <= '0;
      none_cnt_reg <= '0;
    end else if (frame_done) begin
      if (released_reg) begin
        none_cnt_reg <= '0;
        if (!frame_hit_now) begin
          cand_cnt_reg <= '0;
        end else if (accept) begin
          released_reg <= 1'b0;
          cand_cnt_reg <= '0;
        end else begin
          cand_key_reg <= frame_key_now;
          cand_cnt_reg <= cand_cnt_inc;
        end
      end else begin
        cand_cnt_reg <= '0;
        if (frame_hit_now) begin
          none_cnt_reg <= '0;
        end else if (none_cnt_inc == DEB_N) begin
          released_reg <= 1'b1;
          none_cnt_reg <= '0;
        end else begin
          none_cnt_reg <= none_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_OP1;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      case (frame_key_now)
        4'd10:   if (state_reg == ST_OP1) state_next = ST_OP2;
        4'd11:   if (state_reg == ST_OP2) state_next = ST_DONE;
        4'd12:   state_next = ST_OP1;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        op1_reg[i] <= 4'd0;
        op2_reg[i] <= 4'd0;
      end
      cnt1_reg         <= 2'd0;
      cnt2_reg         <= 2'd0;
      tecla_reg        <= 4'd0;
      tecla_valida_reg <= 1'b0;
    end else begin
      tecla_valida_reg <= accept;
      if (accept) tecla_reg <= frame_key_now;
      if (clear_all) begin
        for (int i = 0; i < 3; i++) begin
          op1_reg[i] <= 4'd0;
          op2_reg[i] <= 4'd0;
        end
        cnt1_reg <= 2'd0;
        cnt2_reg <= 2'd0;
      end else if (load1) begin
        op1_reg[0] <= op1_reg[1];
        op1_reg[1] <= op1_reg[2];
        op1_reg[2] <= frame_key_now;
        if (cnt1_reg != 2'd3) cnt1_reg <= cnt1_reg + 2'd1;
      end else if (load2) begin
        op2_reg[0] <= op2_reg[1];
        op2_reg[1] <= op2_reg[2];
        op2_reg[2] <= frame_key_now;
        if (cnt2_reg != 2'd3) cnt2_reg <= cnt2_reg + 2'd1;
      end
    end
  end

  assign filas            = ~(4'b0001 << row_reg);
  assign dig1_1           = op1_reg[0];
  assign dig1_2           = op1_reg[1];
  assign dig1_3           = op1_reg[2];
  assign dig2_1           = op2_reg[0];
  assign dig2_2           = op2_reg[1];
  assign dig2_3           = op2_reg[2];
  assign operandos_listos = (state_reg == ST_DONE);
  assign estado           = state_reg;
  assign tecla            = tecla_reg;
  assign tecla_valida     = tecla_valida_reg;

endmodule

// File: tb/tb_lector_teclado.sv
// Bench for lector_teclado: a keypad model drives the columns; an operand-value model predicts outputs.
module tb_lector_teclado;

  localparam int FRAME = 16;  // SCAN_DIV=4 x 4 rows
`ifdef LECTOR_DESPLAZA_EN
  localparam bit DESP = 1'b1;
`else
  localparam bit DESP = 1'b0;
`endif

  logic       clk, rst;
  logic [3:0] columnas, filas;
  logic [3:0] dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3, tecla;
  logic       operandos_listos, tecla_valida;
  logic [1:0] estado;

  lector_teclado #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst(rst), .columnas(columnas), .filas(filas),
    .dig1_1(dig1_1), .dig1_2(dig1_2), .dig1_3(dig1_3),
    .dig2_1(dig2_1), .dig2_2(dig2_2), .dig2_3(dig2_3),
    .operandos_listos(operandos_listos), .estado(estado),
    .tecla(tecla), .tecla_valida(tecla_valida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: the pressed key pulls its column low while its row is driven.
  int         key_map [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  logic       k_on = 1'b0;
  logic [1:0] k_row = 2'd0, k_col = 2'd0;
  always_comb begin
    columnas = 4'hF;
    if (k_on && filas[k_row] == 1'b0) columnas = ~(4'b0001 << k_col);
  end

  int pulse_cnt = 0;
  always @(negedge clk) if (tecla_valida === 1'b1) pulse_cnt++;

  int vectors = 0, miscompares = 0;
  int exp_pulses = 0, m_state = 0, m_v1 = 0, m_v2 = 0, m_n1 = 0, m_n2 = 0, m_tecla = 0;

  function automatic logic [11:0] bcd3(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic model_reset();
    m_state = 0; m_v1 = 0; m_v2 = 0; m_n1 = 0; m_n2 = 0; m_tecla = 0;
  endtask

  task automatic model_accept(input int k);
    exp_pulses++;
    m_tecla = k;
    if (k == 12) begin
      m_state = 0; m_v1 = 0; m_v2 = 0; m_n1 = 0; m_n2 = 0;
    end else if (k == 10 && m_state == 0) m_state = 1;
    else if (k == 11 && m_state == 1) m_state = 2;
    else if (k <= 9 && m_state == 0 && (m_n1 < 3 || DESP)) begin
      m_v1 = (m_v1 * 10 + k) % 1000; m_n1++;
    end else if (k <= 9 && m_state == 1 && (m_n2 < 3 || DESP)) begin
      m_v2 = (m_v2 * 10 + k) % 1000; m_n2++;
    end
  endtask

  task automatic set_key(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_map[r][c] == k) begin
          k_row = 2'(r); k_col = 2'(c);
        end
  endtask

  // Hold a key for a number of scan frames, then leave the pad idle long enough to rearm.
  task automatic hold_key(input int k, input int frames);
    set_key(k);
    k_on = 1'b1;
    repeat (frames * FRAME) @(negedge clk);
    k_on = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    if (frames >= 4) model_accept(k);
    $display("press key=%0d frames=%0d tecla=%0d estado=%b dig1=%0d%0d%0d dig2=%0d%0d%0d pulses=%0d",
             k, frames, tecla, estado, dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3, pulse_cnt);
  endtask

  task automatic test_scan();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    vectors++;
    if (filas !== 4'b1110) begin
      miscompares++; $display("FAIL scan_start: filas=%b want 1110", filas);
    end
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] want;
      @(posedge clk); #1;
      want = ~(4'b0001 << ((i / 4) % 4));
      vectors++;
      if (filas !== want) begin
        miscompares++; $display("FAIL scan_edge%0d: filas=%b want %b", i, filas, want);
      end
    end
    repeat (4 * FRAME) @(negedge clk);
  endtask

  task automatic test_single_press();
    hold_key(5, 6);
    vectors += 3;
    if (pulse_cnt !== exp_pulses) begin
      miscompares++; $display("FAIL single_pulses: got %0d want %0d", pulse_cnt, exp_pulses);
    end
    if (tecla !== 4'd5) begin
      miscompares++; $display("FAIL single_tecla: got %0d want 5", tecla);
    end
    if (dig1_3 !== 4'd5) begin
      miscompares++; $display("FAIL single_dig1_3: got %0d want 5", dig1_3);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    vectors += 5;
    if (filas !== 4'b1110) begin
      miscompares++; $display("FAIL reset_filas: got %b want 1110", filas);
    end
    if ({dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3} !== 24'h0) begin
      miscompares++; $display("FAIL reset_digits: got %h want 000000", {dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3});
    end
    if (tecla !== 4'd0 || tecla_valida !== 1'b0) begin
      miscompares++; $display("FAIL reset_tecla: got %0d/%b want 0/0", tecla, tecla_valida);
    end
    if (estado !== 2'b00) begin
      miscompares++; $display("FAIL reset_estado: got %b want 00", estado);
    end
    if (operandos_listos !== 1'b0) begin
      miscompares++; $display("FAIL reset_listos: got %b want 0", operandos_listos);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4 * FRAME) @(negedge clk);
  endtask

  task automatic test_short_press();
    hold_key(2, 4);
    hold_key(7, 1);
    vectors += 2;
    if (pulse_cnt !== exp_pulses) begin
      miscompares++; $display("FAIL short_pulses: got %0d want %0d", pulse_cnt, exp_pulses);
    end
    if ({dig1_1, dig1_2, dig1_3} !== bcd3(m_v1)) begin
      miscompares++; $display("FAIL short_dig1: got %h want %h", {dig1_1, dig1_2, dig1_3}, bcd3(m_v1));
    end
  endtask

  task automatic test_operands();
    int seq [9] = '{12, 1, 2, 3, 10, 4, 5, 6, 11};
    foreach (seq[i]) hold_key(seq[i], 4);
    vectors += 4;
    if ({dig1_1, dig1_2, dig1_3} !== 12'h123) begin
      miscompares++; $display("FAIL operands_dig1: got %h want 123", {dig1_1, dig1_2, dig1_3});
    end
    if ({dig2_1, dig2_2, dig2_3} !== 12'h456) begin
      miscompares++; $display("FAIL operands_dig2: got %h want 456", {dig2_1, dig2_2, dig2_3});
    end
    if (estado !== 2'b10 || operandos_listos !== 1'b1) begin
      miscompares++; $display("FAIL operands_done: got %b/%b want 10/1", estado, operandos_listos);
    end
    if (pulse_cnt !== exp_pulses) begin
      miscompares++; $display("FAIL operands_pulses: got %0d want %0d", pulse_cnt, exp_pulses);
    end
  endtask

  task automatic test_done_clear();
    hold_key(8, 4);
    vectors += 3;
    if ({dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3} !== 24'h123456) begin
      miscompares++; $display("FAIL done_ignore8: got %h want 123456", {dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3});
    end
    if (tecla !== 4'd8) begin
      miscompares++; $display("FAIL done_tecla: got %0d want 8", tecla);
    end
    hold_key(12, 4);
    if ({dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3} !== 24'h0 || estado !== 2'b00) begin
      miscompares++; $display("FAIL done_clear: got %h/%b want 000000/00",
                              {dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3}, estado);
    end
  endtask

  task automatic test_fourth_digit();
    logic [11:0] want;
    want = DESP ? 12'h234 : 12'h123;
    hold_key(1, 4); hold_key(2, 4); hold_key(3, 4); hold_key(4, 4);
    vectors += 2;
    if ({dig1_1, dig1_2, dig1_3} !== want) begin
      miscompares++; $display("FAIL fourth_digit: got %h want %h", {dig1_1, dig1_2, dig1_3}, want);
    end
    if (tecla !== 4'd4 || pulse_cnt !== exp_pulses) begin
      miscompares++; $display("FAIL fourth_pulse: got %0d/%0d want 4/%0d", tecla, pulse_cnt, exp_pulses);
    end
  endtask

  task automatic test_rst_debounce();
    set_key(9);
    k_on = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors += 3;
    if ({dig1_1, dig1_2, dig1_3} !== 12'h0 || estado !== 2'b00 || tecla !== 4'd0) begin
      miscompares++; $display("FAIL rstdeb_outputs: got %h/%b/%0d want 000/00/0", {dig1_1, dig1_2, dig1_3}, estado, tecla);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4 * FRAME) @(negedge clk);
    k_on = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    if (pulse_cnt !== exp_pulses) begin
      miscompares++; $display("FAIL rstdeb_pulses: got %0d want %0d", pulse_cnt, exp_pulses);
    end
    if ({dig1_1, dig1_2, dig1_3} !== 12'h0 || tecla !== 4'd0) begin
      miscompares++; $display("FAIL rstdeb_after: got %h/%0d want 000/0", {dig1_1, dig1_2, dig1_3}, tecla);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int k, frames;
      k = int'($urandom_range(0, 15));
      frames = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(4, 6));
      hold_key(k, frames);
      vectors += 5;
      if (pulse_cnt !== exp_pulses) begin
        miscompares++; $display("FAIL rand%0d_pulses: got %0d want %0d", n, pulse_cnt, exp_pulses);
      end
      if (tecla !== 4'(m_tecla)) begin
        miscompares++; $display("FAIL rand%0d_tecla: got %0d want %0d", n, tecla, m_tecla);
      end
      if ({dig1_1, dig1_2, dig1_3} !== bcd3(m_v1)) begin
        miscompares++; $display("FAIL rand%0d_dig1: got %h want %h", n, {dig1_1, dig1_2, dig1_3}, bcd3(m_v1));
      end
      if ({dig2_1, dig2_2, dig2_3} !== bcd3(m_v2)) begin
        miscompares++; $display("FAIL rand%0d_dig2: got %h want %h", n, {dig2_1, dig2_2, dig2_3}, bcd3(m_v2));
      end
      if (estado !== 2'(m_state) || operandos_listos !== (m_state == 2)) begin
        miscompares++; $display("FAIL rand%0d_estado: got %b/%b want %0d", n, estado, operandos_listos, m_state);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_scan();
    test_single_press();
    test_reset();
    test_short_press();
    test_operands();
    test_done_clear();
    test_fourth_digit();
    test_rst_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
